button_reader: RTL and testbench
================================

BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 30'd2500000, consecutive stable cycles required to accept a new button level.
REQ-002 Parameter LONG_CYCLES, default 30'd50000000, cycles btn_level must stay high before a long press is flagged.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_in  input  1  raw asynchronous push-button, high = pressed.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-cycle strobe on accepted press.
REQ-008 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe when a press reaches LONG_CYCLES.
REQ-010 press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer (btn_sync) before any other use; btn_in is never sampled directly.
REQ-012 A 30-bit debounce counter SHALL increment each cycle btn_sync != btn_level and clear to 0 on any cycle btn_sync == btn_level.
REQ-013 When the debounce counter reaches DEBOUNCE_CYCLES-1 with btn_sync still differing, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-014 Latency: a clean btn_in edge SHALL appear on btn_level exactly 2 + DEBOUNCE_CYCLES cycles later.
REQ-015 Any btn_in pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-016 FSM states: RELEASED, PRESSED, HELD; reset state RELEASED.
REQ-017 RELEASED -> PRESSED on the edge btn_level rises; press_pulse SHALL be high for exactly the first cycle btn_level is 1.
REQ-018 PRESSED -> HELD when the hold counter reaches LONG_CYCLES-1 (macro enabled); long_pulse SHALL be high for exactly that one cycle.
REQ-019 PRESSED or HELD -> RELEASED on the edge btn_level falls; release_pulse SHALL be high for exactly the first cycle btn_level is 0.
REQ-020 The hold counter SHALL count only in PRESSED, hold its value in HELD (no second long_pulse per press), and clear in RELEASED.
REQ-021 press_count SHALL increment by 1 coincident with each press_pulse and wrap 8'd255 -> 8'd0 without flag.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle; long_pulse SHALL never coincide with release_pulse.

Reset
REQ-023 While rst is high at a clk edge: synchronizer flops, btn_level, all pulses, press_count, both counters SHALL be 0 and FSM SHALL be RELEASED.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort the operation; no pulse SHALL be emitted during or on the cycle after reset release.
REQ-025 After reset release with btn_in held high, a press SHALL be accepted after the full 2 + DEBOUNCE_CYCLES latency.

Configuration
REQ-026 Macro BUTTON_READER_LONG_PRESS_EN: when defined, hold counter, HELD state and long_pulse SHALL be implemented per REQ-018/020.
REQ-027 When BUTTON_READER_LONG_PRESS_EN is undefined, hold counter and HELD state SHALL be absent, FSM SHALL use RELEASED/PRESSED only, and long_pulse SHALL be tied to 0.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-028 rst high 3 cycles, btn_in=1 -> all outputs 0 throughout; btn_level rises 6 cycles after rst falls.
REQ-029 btn_in high for 3 cycles then low -> btn_level, press_pulse, press_count remain 0.
REQ-030 btn_in rises, held 20 cycles -> btn_level rises 6 cycles later, press_pulse single cycle, press_count=1; btn_in falls -> release_pulse single cycle 6 cycles later.
REQ-031 256 clean presses -> press_count reads 255 after the 255th and 0 after the 256th.
REQ-032 btn_in held 30 cycles with macro -> exactly one long_pulse, 10 cycles after btn_level rises; without macro -> long_pulse stays 0.
REQ-033 rst pulsed 1 cycle at debounce count 2 -> btn_level stays 0, no pulse; acceptance restarts with full 6-cycle latency.

Source files
------------

// File: rtl/button_reader.sv
// Push-button reader: two-flop synchronizer, debounce, press/release/long-press strobes and a press counter.
// Optional long-press detection is built when BUTTON_READER_LONG_PRESS_EN is defined.
module button_reader #(
    parameter logic [29:0] DEBOUNCE_CYCLES = 30'd2500000,
    parameter logic [29:0] LONG_CYCLES     = 30'd50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    // state    | meaning
    // RELEASED | debounced level low, hold counter cleared
    // PRESSED  | debounced level high, hold counter running
    // HELD     | long press already flagged, waiting for release
`ifdef BUTTON_READER_LONG_PRESS_EN
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;
`endif

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic [29:0] deb_cnt_q;
    logic [29:0] deb_cnt_d;
    logic        differ;
    logic        deb_done;
    logic        rise_evt;
    logic        fall_evt;
    state_t      state_q;
    state_t      state_d;
    logic        press_q;
    logic        press_d;
    logic        release_q;
    logic        release_d;
    logic [7:0]  count_q;
    logic [7:0]  count_d;
`ifdef BUTTON_READER_LONG_PRESS_EN
    logic        long_q;
    logic        long_d;
    logic [29:0] hold_cnt_q;
    logic [29:0] hold_cnt_d;
`else
    logic        unused_long_cfg;
    assign unused_long_cfg = ^LONG_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // The level flips on the edge where the counter already sits at DEBOUNCE_CYCLES-1.
    assign differ   = sync2_q ^ level_q;
    assign deb_done = differ && (deb_cnt_q == (DEBOUNCE_CYCLES - 30'd1));
    assign rise_evt = deb_done & ~level_q;
    assign fall_evt = deb_done & level_q;

    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        if (differ) begin
            if (deb_done) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 30'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
`ifdef BUTTON_READER_LONG_PRESS_EN
        long_d     = 1'b0;
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            RELEASED: begin
`ifdef BUTTON_READER_LONG_PRESS_EN
                hold_cnt_d = '0;
`endif
                if (rise_evt) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            PRESSED: begin
                if (fall_evt) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
`ifdef BUTTON_READER_LONG_PRESS_EN
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == (LONG_CYCLES - 30'd1)) begin
                    state_d = HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 30'd1;
`endif
                end
            end
`ifdef BUTTON_READER_LONG_PRESS_EN
            HELD: begin
                if (fall_evt) begin
                    state_d    = RELEASED;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end
            end
`endif
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            long_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            long_q     <= long_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Long-press expectations follow BUTTON_READER_LONG_PRESS_EN as seen by this compile.
module tb_button_reader;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int n_cmp;
    int n_fail;
    int cyc;
    int n_press;
    int n_release;
    int n_long;
    int n_both;
    int n_longrel;
    int press_cyc;
    int long_cyc;
    int p0;
    int r0;
    int l0;

    button_reader #(
        .DEBOUNCE_CYCLES(30'd4),
        .LONG_CYCLES    (30'd10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (press_pulse) begin
            n_press++;
            press_cyc = cyc;
        end
        if (release_pulse) n_release++;
        if (long_pulse) begin
            n_long++;
            long_cyc = cyc;
        end
        if (press_pulse && release_pulse) n_both++;
        if (long_pulse && release_pulse) n_longrel++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        n_press = 0; n_release = 0; n_long = 0;
        n_both = 0; n_longrel = 0; press_cyc = 0; long_cyc = 0;
        rst = 1'b1;
        btn_in = 1'b1;

        // reset held with the button already pressed
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs", {20'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
        end
        rst = 1'b0;
        repeat (5) tick();
        check("post_rst_level_lo", btn_level, 0);
        check("post_rst_no_pulse", n_press + n_release + n_long, 0);
        tick();
        check("post_rst_level_hi", btn_level, 1);
        check("post_rst_press", press_pulse, 1);
        check("post_rst_count", press_count, 1);
        tick();
        check("press_single", press_pulse, 0);

        // clean release
        btn_in = 1'b0;
        repeat (5) tick();
        check("rel_level_still_hi", btn_level, 1);
        check("rel_not_yet", n_release, 0);
        tick();
        check("rel_level_lo", btn_level, 0);
        check("rel_pulse", release_pulse, 1);
        tick();
        check("rel_single", release_pulse, 0);
        check("rel_count", n_release, 1);

        // 3-cycle glitch is rejected
        btn_in = 1'b1;
        repeat (3) tick();
        btn_in = 1'b0;
        repeat (12) tick();
        check("glitch_level", btn_level, 0);
        check("glitch_presses", n_press, 1);
        check("glitch_count", press_count, 1);

        // 4-cycle pulse is just long enough
        btn_in = 1'b1;
        repeat (4) tick();
        btn_in = 1'b0;
        repeat (2) tick();
        check("edge4_level", btn_level, 1);
        check("edge4_press", press_pulse, 1);
        repeat (12) tick();
        check("edge4_level_lo", btn_level, 0);
        check("edge4_count", press_count, 2);
        check("edge4_releases", n_release, 2);

        // long hold
        p0 = n_press; l0 = n_long;
        btn_in = 1'b1;
        repeat (30) tick();
        check("long_press_once", n_press - p0, 1);
`ifdef BUTTON_READER_LONG_PRESS_EN
        check("long_once", n_long - l0, 1);
        check("long_delay", long_cyc - press_cyc, 10);
`else
        check("long_absent", n_long - l0, 0);
`endif
        btn_in = 1'b0;
        repeat (10) tick();
        check("long_rel_level", btn_level, 0);
`ifdef BUTTON_READER_LONG_PRESS_EN
        check("long_no_second", n_long - l0, 1);
`else
        check("long_no_second", n_long - l0, 0);
`endif
        check("long_count", press_count, 3);

        // reset at debounce count 2 aborts and restarts acceptance
        btn_in = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        p0 = n_press; r0 = n_release; l0 = n_long;
        tick();
        check("midrst_outputs", {20'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_after", {20'd0, btn_level, press_pulse, release_pulse, long_pulse, press_count}, 32'd0);
        repeat (4) tick();
        check("midrst_level_lo", btn_level, 0);
        check("midrst_no_pulse", (n_press - p0) + (n_release - r0) + (n_long - l0), 0);
        tick();
        check("midrst_level_hi", btn_level, 1);
        check("midrst_press", press_pulse, 1);
        check("midrst_count", press_count, 1);

        // 256 clean presses from a zeroed counter
        btn_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("wrap_start", press_count, 0);
        for (int k = 1; k <= 256; k++) begin
            btn_in = 1'b1;
            repeat (8) tick();
            btn_in = 1'b0;
            repeat (8) tick();
            if (k == 255) check("wrap_255", press_count, 255);
            if (k == 256) check("wrap_0", press_count, 0);
        end

        check("press_rel_overlap", n_both, 0);
        check("long_rel_overlap", n_longrel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
